uart_tx: RTL and testbench

- Byte-serial UART transmitter. It is the far end of the CPU control unit's STORE-to-0xFE path.
- The control unit pulses uart_tx_in to load the data-bus byte, then pulses uart_send_data to start a frame.
- It stalls its step counter while busyFlag is high.
- Frames are 8N1 (or 8E1 with the optional feature), LSB first, on the tx pin.

---
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter, 8N1 frames (8E1 when UART_TX_PARITY_EN is defined), LSB first.
// Latency: busyFlag and the start bit appear the cycle after the send pulse; busy lasts (DATA_BITS+2[+1])*CLKS_PER_BIT cycles.
// Backpressure: loads and sends are ignored while busyFlag=1; there is no queue, the caller must wait for busyFlag=0.
//
// Optional feature macro: UART_TX_PARITY_EN (inserts an even-parity bit between the data bits and the stop bit).
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   bus_in         data byte, sampled when uart_tx_in=1
//   uart_tx_in     load bus_in into the holding register (ignored while busy)
//   uart_send_data start a frame from the holding register (ignored while busy)
//   busyFlag       high while a frame is in flight
//   tx             serial line, idles high
//   tx_done        one-cycle pulse on the cycle busyFlag falls
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] bus_in,
  input  logic                 uart_tx_in,
  input  logic                 uart_send_data,
  output logic                 busyFlag,
  output logic                 tx,
  output logic                 tx_done
);

  // CLKS_PER_BIT >= 2, so CW >= 1 and the counter always holds CLKS_PER_BIT-1.
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shift;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  wire bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold     <= '0;
      shift    <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      busyFlag <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;

      // A same-edge load and send transmits the old holding value: the
      // shift register copies 'hold' before this edge's load lands.
      if (uart_tx_in && !busyFlag) begin
        hold <= bus_in;
      end

      case (state)
        IDLE: begin
          if (uart_send_data) begin
            shift    <= hold;
            state    <= START;
            busyFlag <= 1'b1;
            tx       <= 1'b0;
            cnt      <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= ^hold;
`endif
          end
        end

        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              // tx takes the next bit directly so it changes on the same
              // edge the shift register advances.
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            cnt      <= '0;
            state    <= IDLE;
            busyFlag <= 1'b0;
            tx_done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with CLKS_PER_BIT=4.
// Inputs are driven just after rising edges or at falling edges; outputs are sampled on falling edges.
// Each scenario task performs its own inline comparisons and bumps the shared counters.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk;
  logic       reset;
  logic [7:0] bus_in;
  logic       uart_tx_in;
  logic       uart_send_data;
  logic       busyFlag;
  logic       tx;
  logic       tx_done;

  int checks;
  int errors;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus_in         (bus_in),
    .uart_tx_in     (uart_tx_in),
    .uart_send_data (uart_send_data),
    .busyFlag       (busyFlag),
    .tx             (tx),
    .tx_done        (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_byte(input logic [7:0] b);
    @(negedge clk);
    bus_in     = b;
    uart_tx_in = 1'b1;
    @(posedge clk);
    #1;
    uart_tx_in = 1'b0;
  endtask

  // Pulses send on the next edge and records the frame. Cycle c counts falling
  // edges after the send edge; inj_c injects a load+send pulse after sample c;
  // b2b stops at the first idle cycle and raises send for the next frame.
  task automatic run_frame(input int inj_c, input logic [7:0] inj_d, input bit b2b,
                           output logic [10:0] bits, output int blen, output int dones,
                           output int done_at, output int glitch, output logic first_busy,
                           output logic idle_tx);
    int last;
    bits = '1; blen = 0; dones = 0; done_at = -1; glitch = 0; first_busy = 1'b0; idle_tx = 1'bx;
    last = b2b ? FL : FL + 3;
    if (!uart_send_data) begin
      @(negedge clk);
      uart_send_data = 1'b1;
    end
    @(posedge clk);
    #1;
    uart_send_data = 1'b0;
    uart_tx_in     = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c == 0) first_busy = busyFlag;
      if (busyFlag === 1'b1) blen++;
      if (tx_done === 1'b1) begin
        dones++;
        done_at = c;
      end
      if (c < FL) begin
        if (c % CPB == 0) bits[c / CPB] = tx;
        else if (tx !== bits[c / CPB]) glitch++;
      end
      if (c == FL) idle_tx = tx;
      if (c == inj_c) begin
        bus_in = inj_d; uart_tx_in = 1'b1; uart_send_data = 1'b1;
      end else if (c == inj_c + 1) begin
        uart_tx_in = 1'b0; uart_send_data = 1'b0;
      end
      if (b2b && c == last) uart_send_data = 1'b1;
    end
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, busyFlag, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state: tx/busy/done=%b required 100", {tx, busyFlag, tx_done});
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({tx, busyFlag, tx_done} !== 3'b100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_20: %0d bad idle cycles, required 0", bad);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] exp_d, input logic [10:0] bits,
                             input int blen, input int dones, input int done_at, input int glitch,
                             input logic first_busy);
    checks++;
    if (bits[8:1] !== exp_d) begin
      errors++;
      $display("FAIL %s_data: got %h required %h", name, bits[8:1], exp_d);
    end
    checks++;
    if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) begin
      errors++;
      $display("FAIL %s_framing: start=%b stop=%b required 0 1", name, bits[0], bits[NB-1]);
    end
    checks++;
    if (blen != FL || first_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: len=%0d first=%b required %0d 1", name, blen, first_busy, FL);
    end
    checks++;
    if (dones != 1 || done_at != FL) begin
      errors++;
      $display("FAIL %s_done: pulses=%0d at=%0d required 1 at %0d", name, dones, done_at, FL);
    end
    checks++;
    if (glitch != 0) begin
      errors++;
      $display("FAIL %s_glitch: %0d mid-bit changes required 0", name, glitch);
    end
  endtask

  task automatic test_frame_a5;
    logic [10:0] bits; int blen, dones, done_at, glitch; logic fb, it;
    load_byte(8'hA5);
    run_frame(-5, 8'h00, 1'b0, bits, blen, dones, done_at, glitch, fb, it);
    check_frame("a5", 8'hA5, bits, blen, dones, done_at, glitch, fb);
    checks++;
    if (bits[9:0] !== 10'b1_10100101_0 && NB == 10) begin
      errors++;
      $display("FAIL a5_seq: got %b required 1101001010", bits[9:0]);
    end
  endtask

  task automatic test_midframe;
    logic [10:0] bits; int blen, dones, done_at, glitch; logic fb, it;
    run_frame(15, 8'hFF, 1'b0, bits, blen, dones, done_at, glitch, fb, it);
    check_frame("mid", 8'hA5, bits, blen, dones, done_at, glitch, fb);
    run_frame(-5, 8'h00, 1'b0, bits, blen, dones, done_at, glitch, fb, it);
    checks++;
    if (bits[8:1] !== 8'hA5) begin
      errors++;
      $display("FAIL mid_hold: got %h required a5", bits[8:1]);
    end
  endtask

  task automatic test_simultaneous;
    logic [10:0] bits; int blen, dones, done_at, glitch; logic fb, it;
    load_byte(8'h11);
    @(negedge clk);
    bus_in = 8'h3C; uart_tx_in = 1'b1; uart_send_data = 1'b1;
    run_frame(-5, 8'h00, 1'b0, bits, blen, dones, done_at, glitch, fb, it);
    check_frame("sim_old", 8'h11, bits, blen, dones, done_at, glitch, fb);
    run_frame(-5, 8'h00, 1'b0, bits, blen, dones, done_at, glitch, fb, it);
    checks++;
    if (bits[8:1] !== 8'h3C) begin
      errors++;
      $display("FAIL sim_new: got %h required 3c", bits[8:1]);
    end
  endtask

  task automatic test_reset_midframe;
    logic [10:0] bits; int blen, dones, done_at, glitch; logic fb, it;
    load_byte(8'h00);
    @(negedge clk);
    uart_send_data = 1'b1;
    @(posedge clk);
    #1;
    uart_send_data = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (busyFlag !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: busy=%b required 1", busyFlag);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({tx, busyFlag, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL rst_async: tx/busy/done=%b required 100", {tx, busyFlag, tx_done});
    end
    @(negedge clk);
    reset = 1'b0;
    load_byte(8'h80);
    run_frame(-5, 8'h00, 1'b0, bits, blen, dones, done_at, glitch, fb, it);
    check_frame("rst_80", 8'h80, bits, blen, dones, done_at, glitch, fb);
  endtask

  task automatic test_back_to_back;
    logic [10:0] bits; int blen, dones, done_at, glitch; logic fb, it;
    load_byte(8'h5A);
    run_frame(-5, 8'h00, 1'b1, bits, blen, dones, done_at, glitch, fb, it);
    check_frame("b2b_1", 8'h5A, bits, blen, dones, done_at, glitch, fb);
    checks++;
    if (it !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap_tx: tx=%b required 1", it);
    end
    run_frame(-5, 8'h00, 1'b0, bits, blen, dones, done_at, glitch, fb, it);
    check_frame("b2b_2", 8'h5A, bits, blen, dones, done_at, glitch, fb);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [10:0] bits; int blen, dones, done_at, glitch; logic fb, it;
    load_byte(8'h07);
    run_frame(-5, 8'h00, 1'b0, bits, blen, dones, done_at, glitch, fb, it);
    check_frame("par_07", 8'h07, bits, blen, dones, done_at, glitch, fb);
    checks++;
    if (bits[9] !== 1'b1 || blen != 44) begin
      errors++;
      $display("FAIL par_07_bit: parity=%b len=%0d required 1 44", bits[9], blen);
    end
    load_byte(8'h03);
    run_frame(-5, 8'h00, 1'b0, bits, blen, dones, done_at, glitch, fb, it);
    checks++;
    if (bits[9] !== 1'b0) begin
      errors++;
      $display("FAIL par_03_bit: parity=%b required 0", bits[9]);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus_in = 8'h00;
    uart_tx_in = 1'b0;
    uart_send_data = 1'b0;
    test_reset;
    test_frame_a5;
    test_midframe;
    test_simultaneous;
    test_reset_midframe;
    test_back_to_back;
`ifdef UART_TX_PARITY_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
